// File: rtl/zbt_pkg.sv
// Shared definitions for the ZBT lattice writer.
//   state_t    : writer sequencing states (IDLE, WRITE, DONE)
//   pack_point : places x/y/z coordinates into a ZBT word, z in the low bits,
//                upper bits zero padded
//   ZBT_WORD_W / ZBT_ADDR_W : default ZBT word and address widths
package zbt_pkg;

  localparam int ZBT_WORD_W = 36;
  localparam int ZBT_ADDR_W = 19;
  // Working width of pack_point; callers cast the result down to their word width.
  localparam int PACK_MAX_W = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Inputs arrive zero-extended, so the OR cannot mix coordinate bits.
  function automatic logic [PACK_MAX_W-1:0] pack_point(
    input logic [PACK_MAX_W-1:0] x,
    input logic [PACK_MAX_W-1:0] y,
    input logic [PACK_MAX_W-1:0] z,
    input int unsigned           coord_w
  );
    pack_point = (x << (2 * coord_w)) | (y << coord_w) | z;
  endfunction

endpackage

// File: rtl/zbt_lattice_writer_if.sv
// Ready/valid write port into the ZBT write path.
//   wr_valid : write request valid (master -> slave)
//   wr_ready : slave accepts the word this cycle (slave -> master)
//   wr_addr  : ZBT write address
//   wr_data  : packed point word
interface zbt_lattice_writer_if #(
  parameter int ADDR_W = zbt_pkg::ZBT_ADDR_W,
  parameter int WORD_W = zbt_pkg::ZBT_WORD_W
);

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);

endinterface

// File: rtl/lattice_counter.sv
// Nested x/y/z lattice index counters with per-axis coordinate accumulators.
// z is innermost, x outermost. Coordinates advance by step and wrap in COORD_W bits.
//   clk, reset   : clock, synchronous active-high reset
//   load         : latch n_per_axis/origin/step and restart at point 0
//   advance      : move to the next lattice point
//   x, y, z      : coordinates of the current point
//   last         : current point is the final one of the lattice
module lattice_counter
  import zbt_pkg::*;
#(
  parameter int COORD_W = 10,
  parameter int CNT_W   = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               advance,
  input  logic [CNT_W-1:0]   n_per_axis,
  input  logic [COORD_W-1:0] origin,
  input  logic [COORD_W-1:0] step,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [COORD_W-1:0] z,
  output logic               last
);

  logic [CNT_W-1:0]   ix_r, iy_r, iz_r, n_r;
  logic [COORD_W-1:0] x_r, y_r, z_r, origin_r, step_r;
  logic [CNT_W-1:0]   top_idx_s;
  logic               x_wrap_s, y_wrap_s, z_wrap_s;

  assign top_idx_s = n_r - CNT_W'(1);
  assign x_wrap_s  = (ix_r == top_idx_s);
  assign y_wrap_s  = (iy_r == top_idx_s);
  assign z_wrap_s  = (iz_r == top_idx_s);

  assign x    = x_r;
  assign y    = y_r;
  assign z    = z_r;
  assign last = x_wrap_s & y_wrap_s & z_wrap_s;

  // Index and coordinate stepping; an axis wrapping back to origin carries into the next.
  always_ff @(posedge clk) begin
    if (reset) begin
      ix_r     <= CNT_W'(0);
      iy_r     <= CNT_W'(0);
      iz_r     <= CNT_W'(0);
      n_r      <= CNT_W'(0);
      x_r      <= COORD_W'(0);
      y_r      <= COORD_W'(0);
      z_r      <= COORD_W'(0);
      origin_r <= COORD_W'(0);
      step_r   <= COORD_W'(0);
    end else if (load) begin
      ix_r     <= CNT_W'(0);
      iy_r     <= CNT_W'(0);
      iz_r     <= CNT_W'(0);
      n_r      <= n_per_axis;
      x_r      <= origin;
      y_r      <= origin;
      z_r      <= origin;
      origin_r <= origin;
      step_r   <= step;
    end else if (advance) begin
      if (z_wrap_s) begin
        iz_r <= CNT_W'(0);
        z_r  <= origin_r;
        if (y_wrap_s) begin
          iy_r <= CNT_W'(0);
          y_r  <= origin_r;
          ix_r <= ix_r + CNT_W'(1);
          x_r  <= x_r + step_r;
        end else begin
          iy_r <= iy_r + CNT_W'(1);
          y_r  <= y_r + step_r;
        end
      end else begin
        iz_r <= iz_r + CNT_W'(1);
        z_r  <= z_r + step_r;
      end
    end
  end

endmodule

// File: rtl/zbt_lattice_writer.sv
// Streams a cubic lattice of signed 3D points into the ZBT write path,
// one packed word {zero pad, x, y, z} per ready/valid transfer.
// Optional feature: define ZBT_LATTICE_CHECKSUM_EN to add the checksum output
// (XOR of all words transferred in the current run).
//   clk, reset   : clock, synchronous active-high reset
//   start        : begin a run (only honoured in IDLE)
//   base_addr    : address of point 0 (latched at start)
//   n_per_axis   : points per axis (latched at start)
//   origin, step : signed start coordinate and increment, all axes (latched)
//   busy, done   : run in progress / one-cycle completion pulse
//   wr           : ZBT write port (master side)
//   point_count  : points written in the current/last run
//   checksum     : (ZBT_LATTICE_CHECKSUM_EN only) XOR of transferred words
module zbt_lattice_writer
  import zbt_pkg::*;
#(
  parameter int COORD_W = 10,
  parameter int WORD_W  = ZBT_WORD_W,
  parameter int ADDR_W  = ZBT_ADDR_W,
  parameter int CNT_W   = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [CNT_W-1:0]        n_per_axis,
  input  logic signed [COORD_W-1:0] origin,
  input  logic signed [COORD_W-1:0] step,
  output logic                    busy,
  output logic                    done,
  zbt_lattice_writer_if.master    wr,
  output logic [3*CNT_W-1:0]      point_count
`ifdef ZBT_LATTICE_CHECKSUM_EN
  ,
  output logic [WORD_W-1:0]       checksum
`endif
);

  localparam int PC_W = 3 * CNT_W;

  if (WORD_W < 3 * COORD_W) begin : g_word_too_narrow
    $error("zbt_lattice_writer: WORD_W must be >= 3*COORD_W");
  end
  if (WORD_W > PACK_MAX_W) begin : g_word_too_wide
    $error("zbt_lattice_writer: WORD_W exceeds pack_point working width");
  end

  state_t             state_r;
  logic               load_s, advance_s, last_s;
  logic [COORD_W-1:0] x_s, y_s, z_s;

  // Counter restarts on any accepted start; it steps only on a real transfer.
  assign load_s    = (state_r == IDLE) & start;
  assign advance_s = wr.wr_valid & wr.wr_ready;

  lattice_counter #(
    .COORD_W (COORD_W),
    .CNT_W   (CNT_W)
  ) u_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (load_s),
    .advance    (advance_s),
    .n_per_axis (n_per_axis),
    .origin     (origin),
    .step       (step),
    .x          (x_s),
    .y          (y_s),
    .z          (z_s),
    .last       (last_s)
  );

  // Word is a pure rewiring of the counter's coordinate registers.
  assign wr.wr_data = WORD_W'(pack_point({{(PACK_MAX_W-COORD_W){1'b0}}, x_s},
                                         {{(PACK_MAX_W-COORD_W){1'b0}}, y_s},
                                         {{(PACK_MAX_W-COORD_W){1'b0}}, z_s},
                                         COORD_W));

  // Run sequencing: start latch, per-transfer bookkeeping and done/busy generation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      wr.wr_valid <= 1'b0;
      wr.wr_addr  <= ADDR_W'(0);
      point_count <= PC_W'(0);
`ifdef ZBT_LATTICE_CHECKSUM_EN
      checksum    <= WORD_W'(0);
`endif
    end else begin
      case (state_r)
        IDLE: begin
          done        <= 1'b0;
          busy        <= 1'b0;
          wr.wr_valid <= 1'b0;
          if (start) begin
            point_count <= PC_W'(0);
            wr.wr_addr  <= base_addr;
`ifdef ZBT_LATTICE_CHECKSUM_EN
            checksum    <= WORD_W'(0);
`endif
            busy        <= 1'b1;
            if (n_per_axis != CNT_W'(0)) begin
              state_r     <= WRITE;
              wr.wr_valid <= 1'b1;
            end else begin
              // Empty lattice: skip straight to the completion pulse.
              state_r <= DONE;
              done    <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (wr.wr_valid & wr.wr_ready) begin
            point_count <= point_count + PC_W'(1);
            wr.wr_addr  <= wr.wr_addr + ADDR_W'(1);
`ifdef ZBT_LATTICE_CHECKSUM_EN
            checksum    <= checksum ^ wr.wr_data;
`endif
            if (last_s) begin
              state_r     <= DONE;
              wr.wr_valid <= 1'b0;
              done        <= 1'b1;
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state_r     <= IDLE;
          done        <= 1'b0;
          busy        <= 1'b0;
          wr.wr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zbt_lattice_writer.sv
// Self-checking bench for zbt_lattice_writer: directed lattice runs plus
// randomized runs compared against a nested-loop reference of the lattice.
module tb_zbt_lattice_writer;

  localparam int COORD_W = 10;
  localparam int WORD_W  = 36;
  localparam int ADDR_W  = 19;
  localparam int CNT_W   = 6;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic [ADDR_W-1:0]   base_addr;
  logic [CNT_W-1:0]    n_per_axis;
  logic [COORD_W-1:0]  origin;
  logic [COORD_W-1:0]  step;
  logic                busy;
  logic                done;
  logic [3*CNT_W-1:0]  point_count;
`ifdef ZBT_LATTICE_CHECKSUM_EN
  logic [WORD_W-1:0]   checksum;
`endif

  zbt_lattice_writer_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) wr_bus ();

  zbt_lattice_writer #(
    .COORD_W (COORD_W),
    .WORD_W  (WORD_W),
    .ADDR_W  (ADDR_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .base_addr   (base_addr),
    .n_per_axis  (n_per_axis),
    .origin      (origin),
    .step        (step),
    .busy        (busy),
    .done        (done),
    .wr          (wr_bus),
    .point_count (point_count)
`ifdef ZBT_LATTICE_CHECKSUM_EN
    ,
    .checksum    (checksum)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [WORD_W-1:0] obs_data_q[$];
  logic [ADDR_W-1:0] obs_addr_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [COORD_W-1:0] coord(input int org, input int stp, input int k);
    return COORD_W'(org + k * stp);
  endfunction

  // One complete run: drive start, follow every cycle against the reference lattice.
  task automatic run(input int n, input int org, input int stp, input int base,
                     input int mode, input bit hold);
    logic [ADDR_W-1:0] exp_addr[$];
    logic [WORD_W-1:0] exp_data[$];
    logic [WORD_W-1:0] exp_sum;
    int total, k, cyc;
    bit done_seen, rdy;
    exp_sum = '0;
    for (int ix = 0; ix < n; ix++)
      for (int iy = 0; iy < n; iy++)
        for (int iz = 0; iz < n; iz++) begin
          exp_addr.push_back(ADDR_W'(base + (ix * n + iy) * n + iz));
          exp_data.push_back({6'd0, coord(org, stp, ix), coord(org, stp, iy), coord(org, stp, iz)});
        end
    total = n * n * n;
    obs_data_q.delete();
    obs_addr_q.delete();
    n_per_axis = CNT_W'(n);
    origin     = COORD_W'(org);
    step       = COORD_W'(stp);
    base_addr  = ADDR_W'(base);
    start      = 1'b1;
    k = 0;
    cyc = 0;
    done_seen = 1'b0;
    while (!done_seen && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (!hold) start = 1'b0;
      check("busy", 64'(busy), 64'(1));
      if (k < total) begin
        check("wr_valid", 64'(wr_bus.wr_valid), 64'(1));
        check("done early", 64'(done), 64'(0));
        check("wr_addr", 64'(wr_bus.wr_addr), 64'(exp_addr[k]));
        check("wr_data", 64'(wr_bus.wr_data), 64'(exp_data[k]));
        check("point_count run", 64'(point_count), 64'(k));
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = (cyc % 2 == 1);
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        wr_bus.wr_ready = rdy;
        if (rdy) begin
          obs_data_q.push_back(wr_bus.wr_data);
          obs_addr_q.push_back(wr_bus.wr_addr);
          exp_sum = exp_sum ^ exp_data[k];
          k++;
        end
      end else begin
        check("wr_valid at done", 64'(wr_bus.wr_valid), 64'(0));
        check("done", 64'(done), 64'(1));
        check("point_count done", 64'(point_count), 64'(total));
`ifdef ZBT_LATTICE_CHECKSUM_EN
        check("checksum", 64'(checksum), 64'(exp_sum));
`endif
        if (mode == 0) check("done latency", 64'(cyc), 64'(total + 1));
        done_seen = 1'b1;
      end
    end
    if (!done_seen) check("run timeout", 64'(0), 64'(1));
    @(negedge clk);
    check("done width", 64'(done), 64'(0));
    check("busy idle", 64'(busy), 64'(0));
    check("wr_valid idle", 64'(wr_bus.wr_valid), 64'(0));
    check("point_count hold", 64'(point_count), 64'(total));
  endtask

  initial begin
    int n, org, stp, base, mode;
    reset = 1'b1;
    start = 1'b0;
    base_addr = '0;
    n_per_axis = '0;
    origin = '0;
    step = '0;
    wr_bus.wr_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst busy", 64'(busy), 64'(0));
    check("rst done", 64'(done), 64'(0));
    check("rst wr_valid", 64'(wr_bus.wr_valid), 64'(0));
    check("rst wr_addr", 64'(wr_bus.wr_addr), 64'(0));
    check("rst wr_data", 64'(wr_bus.wr_data), 64'(0));
    check("rst point_count", 64'(point_count), 64'(0));
`ifdef ZBT_LATTICE_CHECKSUM_EN
    check("rst checksum", 64'(checksum), 64'(0));
`endif
    reset = 1'b0;
    @(negedge clk);

    // n=3 full-rate run with known corner words.
    run(3, -100, 100, 0, 0, 1'b0);
    check("n3 writes", 64'(obs_data_q.size()), 64'(27));
    check("n3 addr0 data", 64'(obs_data_q[0]), 64'(36'b000000_1110011100_1110011100_1110011100));
    check("n3 addr13 data", 64'(obs_data_q[13]), 64'(0));
    check("n3 addr26 data", 64'(obs_data_q[26]), 64'(36'b000000_0001100100_0001100100_0001100100));
    check("n3 addr26", 64'(obs_addr_q[26]), 64'(26));

    // Same lattice with alternating ready.
    run(3, -100, 100, 0, 1, 1'b0);
    check("n3 toggle writes", 64'(obs_addr_q.size()), 64'(27));

    // Empty lattice.
    run(0, 5, 7, 100, 0, 1'b0);

    // Address and coordinate wrap.
    run(2, 500, 100, 19'h7FFFF, 0, 1'b0);
    check("wrap addr0", 64'(obs_addr_q[0]), 64'(19'h7FFFF));
    check("wrap addr1", 64'(obs_addr_q[1]), 64'(0));
    check("wrap addr7", 64'(obs_addr_q[7]), 64'(6));
    check("wrap x upper", 64'(obs_data_q[4][29:20]), 64'(10'h258));

    // Reset while presenting the 5th write of an n=4 run.
    n_per_axis = 6'd4;
    origin = 10'd3;
    step = 10'd7;
    base_addr = 19'd1000;
    start = 1'b1;
    wr_bus.wr_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    check("pre-reset addr", 64'(wr_bus.wr_addr), 64'(1004));
    reset = 1'b1;
    @(negedge clk);
    check("mid-reset wr_valid", 64'(wr_bus.wr_valid), 64'(0));
    check("mid-reset busy", 64'(busy), 64'(0));
    check("mid-reset done", 64'(done), 64'(0));
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("post-reset wr_valid", 64'(wr_bus.wr_valid), 64'(0));
      check("post-reset done", 64'(done), 64'(0));
    end
    run(4, 3, 7, 1000, 0, 1'b0);

    // start held high: one run per IDLE entry, next run straight after IDLE.
    run(2, -3, 5, 10, 2, 1'b1);
    run(2, -3, 5, 10, 2, 1'b0);

    // Randomized runs.
    for (int r = 0; r < 12; r++) begin
      n    = int'($urandom_range(0, 4));
      org  = int'($urandom_range(0, 1023)) - 512;
      stp  = int'($urandom_range(0, 600)) - 300;
      base = (r % 3 == 0) ? int'($urandom_range(524260, 524287)) : int'($urandom_range(0, 524287));
      mode = int'($urandom_range(0, 2));
      run(n, org, stp, base, mode, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
